// File: rtl/reg_pkg.sv
// Shared encodings for the register-pair sequencer: request ops, pair codes,
// register-file selects, FSM state codes and the pair-to-select mapping.
package reg_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INC   = 2'd2,
    OP_DEC   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    PAIR_BC  = 2'd0,
    PAIR_DE  = 2'd1,
    PAIR_HL  = 2'd2,
    PAIR_BAD = 2'd3
  } pair_e;

  localparam logic [2:0] REG_B    = 3'd0;
  localparam logic [2:0] REG_C    = 3'd1;
  localparam logic [2:0] REG_D    = 3'd2;
  localparam logic [2:0] REG_E    = 3'd3;
  localparam logic [2:0] REG_H    = 3'd4;
  localparam logic [2:0] REG_L    = 3'd5;
  localparam logic [2:0] REG_ZERO = 3'd6;
  localparam logic [2:0] REG_A    = 3'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WR_LO = 3'd2;
  localparam logic [2:0] ST_WR_HI = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // High byte of a pair lives at the even select, low byte at the odd one.
  function automatic logic [2:0] pair_hi_sel(input logic [1:0] pair);
    return {pair, 1'b0};
  endfunction

  function automatic logic [2:0] pair_lo_sel(input logic [1:0] pair);
    return {pair, 1'b1};
  endfunction

endpackage

// File: rtl/reg_pair_seq_if.sv
// Request/response handshake plus register-file port bundle for reg_pair_seq.
interface reg_pair_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_pair;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  rf_out1_sel;
  logic [2:0]  rf_out2_sel;
  logic [7:0]  rf_out1;
  logic [7:0]  rf_out2;
  logic [7:0]  rf_data_in;
  logic [2:0]  rf_data_in_sel;
  logic        rf_write_reg;

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_pair, req_data, rsp_ready, rf_out1, rf_out2,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           rf_out1_sel, rf_out2_sel, rf_data_in, rf_data_in_sel, rf_write_reg
  );

  // Requester / register-file side
  modport master (
    output req_valid, req_op, req_pair, req_data, rsp_ready, rf_out1, rf_out2,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           rf_out1_sel, rf_out2_sel, rf_data_in, rf_data_in_sel, rf_write_reg
  );
endinterface

// File: rtl/pair_incdec.sv
// Combinational 16-bit increment/decrement, wrapping modulo 2^16.
module pair_incdec (
  input  logic [15:0] i_operand,
  input  logic        i_dec,
  output logic [15:0] o_result
);

  // Single adder path selected by direction
  always_comb begin
    o_result = i_dec ? (i_operand - 16'd1) : (i_operand + 16'd1);
  end

endmodule

// File: rtl/reg_pair_seq.sv
// Register-pair sequencer: turns 16-bit pair requests into register-file
// read-select and single-port write cycles, then returns a 16-bit response.
module reg_pair_seq
  import reg_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  reg_pair_seq_if.slave bus
);

  logic [2:0]  r_state;
  op_e         r_op;
  logic [1:0]  r_pair;
  logic [15:0] r_result;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;

  logic [15:0] w_operand;
  logic [15:0] w_incdec;
  logic        w_dec;
  logic [2:0]  w_hi_sel;
  logic [2:0]  w_lo_sel;

  assign w_operand = {bus.rf_out1, bus.rf_out2};
  assign w_dec     = (r_op == OP_DEC);
  assign w_hi_sel  = pair_hi_sel(r_pair);
  assign w_lo_sel  = pair_lo_sel(r_pair);

  pair_incdec u_incdec (
    .i_operand (w_operand),
    .i_dec     (w_dec),
    .o_result  (w_incdec)
  );

  // Sequencer FSM and captured request/result/response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_READ;
      r_pair     <= '0;
      r_result   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_op     <= op_e'(bus.req_op);
            r_pair   <= bus.req_pair;
            r_result <= bus.req_data;
            if (bus.req_pair == PAIR_BAD) begin
              r_rsp_err  <= 1'b1;
              r_rsp_data <= '0;
              r_state    <= ST_RESP;
            end else begin
              r_rsp_err <= 1'b0;
              r_state   <= (op_e'(bus.req_op) == OP_WRITE) ? ST_WR_LO : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_op == OP_READ) begin
            r_rsp_data <= w_operand;
            r_state    <= ST_RESP;
          end else begin
            r_result <= w_incdec;
            r_state  <= ST_WR_LO;
          end
        end
        ST_WR_LO: r_state <= ST_WR_HI;
        ST_WR_HI: begin
          r_rsp_data <= r_result;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs; all fall to zero as soon as reset clears the state.
  // req_ready also looks at reset directly so it stays low while reset is held.
  always_comb begin
    bus.req_ready      = (r_state == ST_IDLE) && !reset;
    bus.rsp_valid      = (r_state == ST_RESP);
    bus.rsp_data       = r_rsp_data;
    bus.rsp_err        = r_rsp_err;
    bus.rf_out1_sel    = '0;
    bus.rf_out2_sel    = '0;
    bus.rf_write_reg   = 1'b0;
    bus.rf_data_in     = '0;
    bus.rf_data_in_sel = '0;
    case (r_state)
      ST_READ: begin
        bus.rf_out1_sel = w_hi_sel;
        bus.rf_out2_sel = w_lo_sel;
      end
      ST_WR_LO: begin
        bus.rf_write_reg   = 1'b1;
        bus.rf_data_in_sel = w_lo_sel;
        bus.rf_data_in     = r_result[7:0];
      end
      ST_WR_HI: begin
        bus.rf_write_reg   = 1'b1;
        bus.rf_data_in_sel = w_hi_sel;
        bus.rf_data_in     = r_result[15:8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_pair_seq.sv
// Directed bench for reg_pair_seq wired to a behavioural register file,
// with a response scoreboard fed from a shadow model of register contents.
module tb_reg_pair_seq;
  import reg_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  reg_pair_seq_if bus ();

  reg_pair_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural register file: combinational reads, select 6 reads zero
  logic [7:0] mem [0:7] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'hA5};
  logic [7:0] mdl [0:7] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'hA5};

  assign bus.rf_out1 = (bus.rf_out1_sel == REG_ZERO) ? 8'h00 : mem[bus.rf_out1_sel];
  assign bus.rf_out2 = (bus.rf_out2_sel == REG_ZERO) ? 8'h00 : mem[bus.rf_out2_sel];

  always @(posedge clock) begin
    if (bus.rf_write_reg && bus.rf_data_in_sel != REG_ZERO)
      mem[bus.rf_data_in_sel] <= bus.rf_data_in;
  end

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  pair;
    logic [15:0] data;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic logic [2:0] hi_of(input logic [1:0] p);
    case (p)
      2'd0:    return REG_B;
      2'd1:    return REG_D;
      default: return REG_H;
    endcase
  endfunction

  function automatic logic [2:0] lo_of(input logic [1:0] p);
    case (p)
      2'd0:    return REG_C;
      2'd1:    return REG_E;
      default: return REG_L;
    endcase
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one request for a single accept cycle; push its expected response.
  task automatic issue(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] data);
    exp_t e;
    logic [15:0] cur;
    e.op   = op;
    e.pair = pair;
    e.err  = (pair == 2'd3);
    e.data = 16'h0000;
    e.lat  = 1;
    if (!e.err) begin
      cur = {mdl[hi_of(pair)], mdl[lo_of(pair)]};
      case (op)
        2'd0:    begin e.data = cur;          e.lat = 2; end
        2'd1:    begin e.data = data;         e.lat = 3; end
        2'd2:    begin e.data = cur + 16'd1;  e.lat = 4; end
        default: begin e.data = cur - 16'd1;  e.lat = 4; end
      endcase
      if (op != 2'd0) begin
        mdl[hi_of(pair)] = e.data[15:8];
        mdl[lo_of(pair)] = e.data[7:0];
      end
    end
    sb.push_back(e);
    bus.req_op    = op;
    bus.req_pair  = pair;
    bus.req_data  = data;
    bus.req_valid = 1'b1;
    chk1("accept_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall it.
  task automatic finish_rsp(input int unsigned hold);
    exp_t e;
    int unsigned n;
    logic [10:0] wlog[$];
    logic [2:0] s1, s2;
    logic readlike;
    n  = 1;
    s1 = '0;
    s2 = '0;
    while (!bus.rsp_valid && n < 12) begin
      if (n == 1) begin
        s1 = bus.rf_out1_sel;
        s2 = bus.rf_out2_sel;
      end
      if (bus.rf_write_reg) wlog.push_back({bus.rf_data_in_sel, bus.rf_data_in});
      tick();
      n++;
    end
    chk1("rsp_valid", bus.rsp_valid, 1'b1);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow observed=%0d expected=nonzero", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      readlike = !e.err && (e.op != 2'd1);
      chk16("latency", 16'(n), 16'(e.lat));
      chk16("rsp_data", bus.rsp_data, e.data);
      chk1("rsp_err", bus.rsp_err, e.err);
      chk16("rd_sel_hi", 16'(s1), readlike ? 16'(hi_of(e.pair)) : 16'h0000);
      chk16("rd_sel_lo", 16'(s2), readlike ? 16'(lo_of(e.pair)) : 16'h0000);
      chk16("wr_count", 16'(wlog.size()), (!e.err && e.op != 2'd0) ? 16'd2 : 16'd0);
      if (!e.err && e.op != 2'd0 && wlog.size() == 2) begin
        chk16("wr_lo", 16'(wlog[0]), 16'({lo_of(e.pair), e.data[7:0]}));
        chk16("wr_hi", 16'(wlog[1]), 16'({hi_of(e.pair), e.data[15:8]}));
      end
      if (!e.err)
        chk16("rf_pair", {mem[hi_of(e.pair)], mem[lo_of(e.pair)]},
              {mdl[hi_of(e.pair)], mdl[lo_of(e.pair)]});
      chk16("rf_a", 16'(mem[REG_A]), 16'(mdl[REG_A]));
      for (int unsigned i = 0; i < hold; i++) begin
        tick();
        chk1("hold_valid", bus.rsp_valid, 1'b1);
        chk16("hold_data", bus.rsp_data, e.data);
        chk1("hold_req_ready", bus.req_ready, 1'b0);
        chk1("hold_no_write", bus.rf_write_reg, 1'b0);
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk1("rsp_drop", bus.rsp_valid, 1'b0);
    chk1("ready_after", bus.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_pair  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_write", bus.rf_write_reg, 1'b0);
    chk16("rst_data_in", 16'(bus.rf_data_in), 16'h0000);
    chk16("rst_sels", 16'({bus.rf_out1_sel, bus.rf_out2_sel, bus.rf_data_in_sel}), 16'h0000);
    chk16("rst_rsp_data", bus.rsp_data, 16'h0000);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    reset = 1'b0;
    #1;
    chk1("post_rst_ready", bus.req_ready, 1'b1);

    // WRITE HL then READ HL
    issue(OP_WRITE, PAIR_HL, 16'hBEEF);
    finish_rsp(0);
    issue(OP_READ, PAIR_HL, 16'h0000);
    finish_rsp(0);

    // INC BC wrapping from 0xFFFF
    issue(OP_WRITE, PAIR_BC, 16'hFFFF);
    finish_rsp(0);
    issue(OP_INC, PAIR_BC, 16'h0000);
    finish_rsp(0);
    issue(OP_READ, PAIR_BC, 16'h0000);
    finish_rsp(0);

    // DEC DE with borrow across bytes
    issue(OP_WRITE, PAIR_DE, 16'h0100);
    finish_rsp(0);
    issue(OP_DEC, PAIR_DE, 16'h0000);
    finish_rsp(0);
    chk16("hl_unchanged", {mem[REG_H], mem[REG_L]}, 16'hBEEF);
    chk16("a_unchanged", 16'(mem[REG_A]), 16'h00A5);

    // Illegal pair under several ops
    issue(OP_READ, PAIR_BAD, 16'h0000);
    finish_rsp(0);
    issue(OP_WRITE, PAIR_BAD, 16'hFFFF);
    finish_rsp(0);
    issue(OP_DEC, PAIR_BAD, 16'h0000);
    finish_rsp(0);

    // Response backpressure with a request held pending
    issue(OP_WRITE, PAIR_BC, 16'h5A3C);
    finish_rsp(0);
    issue(OP_READ, PAIR_BC, 16'h0000);
    bus.req_op    = OP_WRITE;
    bus.req_pair  = PAIR_DE;
    bus.req_data  = 16'h1111;
    bus.req_valid = 1'b1;
    finish_rsp(3);
    issue(OP_WRITE, PAIR_DE, 16'h1111);
    finish_rsp(0);

    // Reset during WR_HI of WRITE BC 0x1234: partial write, no response
    bus.req_op    = OP_WRITE;
    bus.req_pair  = PAIR_BC;
    bus.req_data  = 16'h1234;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk1("mid_wr_lo", bus.rf_write_reg, 1'b1);
    tick();
    chk1("mid_wr_hi", bus.rf_write_reg, 1'b1);
    chk16("mid_wr_hi_sel", 16'(bus.rf_data_in_sel), 16'(REG_B));
    reset = 1'b1;
    #1;
    chk1("rst_write_drop", bus.rf_write_reg, 1'b0);
    chk16("rst_data_drop", 16'(bus.rf_data_in), 16'h0000);
    chk1("rst_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk1("ready_after_rst", bus.req_ready, 1'b1);
    chk16("partial_c", 16'(mem[REG_C]), 16'h0034);
    chk16("kept_b", 16'(mem[REG_B]), 16'(mdl[REG_B]));
    mdl[REG_C] = 8'h34;
    tick();
    chk1("no_rsp_1", bus.rsp_valid, 1'b0);
    tick();
    chk1("no_rsp_2", bus.rsp_valid, 1'b0);
    issue(OP_READ, PAIR_BC, 16'h0000);
    finish_rsp(0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_pair_seq.md
Name: reg_pair_seq

Overview:
- Client-side sequencer for the 8-bit CPU register file (B,C,D,E,H,L,A; select 6 reads as zero).
- Accepts 16-bit register-pair requests (read, write, increment, decrement) on a valid/ready handshake.
- Turns each request into register-file read-select and write-port cycles, then returns a 16-bit response.
- Sits between decode/control and the register file; single write port means 16-bit writes take two cycles.

Parameters:
- None. Fixed 8-bit register file, 3-bit selects.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  0=READ, 1=WRITE, 2=INC, 3=DEC
- req_pair  in  2  0=BC, 1=DE, 2=HL, 3=illegal
- req_data  in  16  write data (WRITE only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  16  pair value read or written
- rsp_err  out  1  illegal pair code
- rf_out1_sel  out  3  register-file read select 1 (high byte)
- rf_out2_sel  out  3  register-file read select 2 (low byte)
- rf_out1  in  8  register-file read data 1 (combinational)
- rf_out2  in  8  register-file read data 2 (combinational)
- rf_data_in  out  8  register-file write data
- rf_data_in_sel  out  3  register-file write select
- rf_write_reg  out  1  register-file write enable

Behaviour:
- Clock and reset: one clock, `clock`. Reset is `reset`, asynchronous and active-high.
- Reset values: state=IDLE; rf_write_reg, rf_data_in, all selects, rsp_valid, rsp_data and rsp_err are 0; req_ready is 0 while reset is high.
- Pair mapping: high select = {pair,0}, low select = {pair,1}, i.e. BC→0/1, DE→2/3, HL→4/5. Selects 6 (zero) and 7 (A) are never targeted.
- FSM states: IDLE, READ, WR_LO, WR_HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch op, pair and data.
  - Next state: pair==3 → RESP with rsp_err=1, rsp_data=0 and no register-file activity.
  - Otherwise WRITE → WR_LO with result=req_data.
  - Otherwise READ/INC/DEC → READ.
- READ:
  - Drive rf_out1_sel=high, rf_out2_sel=low.
  - Capture operand={rf_out1,rf_out2} at the clock edge.
  - READ op → RESP with rsp_data=operand.
  - INC → result=operand+1; DEC → result=operand-1; both modulo 2^16 (0xFFFF+1=0x0000, 0x0000-1=0xFFFF), then → WR_LO.
  - No flags are produced.
- WR_LO: rf_write_reg=1, rf_data_in_sel=low, rf_data_in=result[7:0]; → WR_HI.
- WR_HI: rf_write_reg=1, rf_data_in_sel=high, rf_data_in=result[15:8]; → RESP, rsp_data=result.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable.
  - req_ready=0.
  - On rsp_ready → IDLE with rsp_valid=0. The next request can be accepted the cycle after.
- Outside WR_LO/WR_HI: rf_write_reg=0 and rf_data_in=0. Outside READ: read selects are 0.
- Latency from the accept edge to rsp_valid: READ 2, WRITE 3, INC/DEC 4, illegal 1.
- Reset mid-operation: all outputs drop to reset values immediately (asynchronous). A request interrupted after WR_LO leaves a partial write (low byte updated, high byte old). No response is issued for that request.
- req_valid while busy: ignored, not latched; the requester holds it.

Decomposition:
- Shared package reg_pkg:
  - op encodings READ/WRITE/INC/DEC;
  - pair encodings BC/DE/HL;
  - register selects REG_B..REG_L, REG_ZERO=6, REG_A=7;
  - FSM state enum.
- One natural sub-module, pair_incdec: combinational 16-bit ±1, inputs operand and dec, output result.

Test Plan:
- Bench wires the sequencer to a real register file instance.
- WRITE HL 0xBEEF → cycle+1: write sel 5 data 0xEF; cycle+2: write sel 4 data 0xBE; cycle+3: rsp_data=0xBEEF, rsp_err=0. A following READ HL → rsp_data=0xBEEF two cycles after accept.
- BC=0xFFFF, INC BC → writes C=0x00 then B=0x00; rsp_data=0x0000. A following READ BC returns 0x0000.
- DE=0x0100, DEC DE → writes E=0xFF then D=0x00; rsp_data=0x00FF. HL and A unchanged.
- req_pair=3 with any op → rsp_valid one cycle after accept, rsp_err=1, rsp_data=0, rf_write_reg never asserted.
- READ BC with rsp_ready low 3 cycles → rsp_valid and rsp_data stable throughout. req_ready=0; a concurrent held req_valid (WRITE DE 0x1111) is accepted only the cycle after the response handshake.
- WRITE BC 0x1234 with reset asserted during WR_HI → rf_write_reg falls immediately. C=0x34, B keeps its old value, no rsp_valid. req_ready=1 the first cycle after reset deasserts.
